// File: rtl/dlx_exec_pipe.sv
// -----------------------------------------------------------------------------
// dlx_exec_pipe
//   Two-stage pipelined execute unit for the DLX datapath.
//   Stage 1 registers the decoded class/op and the selected A/B operands plus
//   store data. Stage 2 computes and registers the result, carry/overflow flags
//   and store controls. Both stages advance under a valid/ready handshake and
//   freeze completely when en_ex is low.
//
// Ports
//   clk, rst        single clock, synchronous active-high reset
//   en_ex           global enable; 0 freezes both stages
//   in_valid/ready  input handshake (in_ready is combinational)
//   cntrl_in        [5:4] class, [3] imm_sel, [2:0] op
//   src1, src2, imm operand A, operand B / store data, sign-extended immediate
//   out_valid/ready output handshake (out_valid is registered)
//   aluout          result or memory address
//   carry, overflow carry/shift-out flag, signed overflow (ADD/SUB)
//   mem_wr_en       store request, only high together with out_valid
//   mem_write_out   store data
// -----------------------------------------------------------------------------
module dlx_exec_pipe #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_ex,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       cntrl_in,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  input  logic [WIDTH-1:0] imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] aluout,
  output logic             carry,
  output logic             overflow,
  output logic             mem_wr_en,
  output logic [WIDTH-1:0] mem_write_out
);

  // Shift-amount width, derived from WIDTH only.
  localparam int SHW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    CLS_ARITH = 2'b00,
    CLS_LOGIC = 2'b01,
    CLS_SHIFT = 2'b10,
    CLS_MEM   = 2'b11
  } cls_e;

  // ---------------------------------------------------------------------------
  // Pipeline control
  // ---------------------------------------------------------------------------
  logic s1_valid;
  logic s1_adv;
  logic s2_adv;

  assign s2_adv   = en_ex & (~out_valid | out_ready);
  assign s1_adv   = en_ex & (~s1_valid | s2_adv);
  assign in_ready = s1_adv;

  // ---------------------------------------------------------------------------
  // Stage 1: decode and operand selection
  // ---------------------------------------------------------------------------
  cls_e             in_cls;
  logic [WIDTH-1:0] in_b;

  assign in_cls = cls_e'(cntrl_in[5:4]);
  // The mem class always forms its address from imm; src2 is the store data.
  assign in_b   = (cntrl_in[3] || (in_cls == CLS_MEM)) ? imm : src2;

  cls_e             s1_cls;
  logic [2:0]       s1_op;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [WIDTH-1:0] s1_d;

  // NOTE: clocked state uses non-blocking (<=) so every register samples the
  // pre-edge value of the others; blocking here would chain stages in one edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_cls   <= CLS_ARITH;
      s1_op    <= '0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_d     <= '0;
    end else if (s1_adv) begin
      // A cycle with in_valid low loads a bubble that then flows down.
      s1_valid <= in_valid;
      s1_cls   <= in_cls;
      s1_op    <= cntrl_in[2:0];
      s1_a     <= src1;
      s1_b     <= in_b;
      s1_d     <= src2;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2 datapath
  // ---------------------------------------------------------------------------
  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   sub_sum;
  logic             add_ovf;
  logic             sub_ovf;
  logic             slt;
  logic             sltu;
  logic [SHW-1:0]   amt;
  logic [SHW:0]     rot_inv;
  logic [WIDTH:0]   sll_ext;
  logic [WIDTH:0]   srl_ext;
  logic [WIDTH:0]   sra_ext;
  logic [WIDTH-1:0] rol;
  logic [WIDTH-1:0] ror;

  assign add_sum = {1'b0, s1_a} + {1'b0, s1_b};
  // SUB as A + ~B + 1, so carry-out = 1 means "no borrow".
  assign sub_sum = {1'b0, s1_a} + {1'b0, ~s1_b} + {{WIDTH{1'b0}}, 1'b1};
  assign add_ovf = (s1_a[WIDTH-1] == s1_b[WIDTH-1]) && (add_sum[WIDTH-1] != s1_a[WIDTH-1]);
  assign sub_ovf = (s1_a[WIDTH-1] != s1_b[WIDTH-1]) && (sub_sum[WIDTH-1] != s1_a[WIDTH-1]);
  assign slt     = $signed(s1_a) < $signed(s1_b);
  assign sltu    = s1_a < s1_b;

  // Shifts run one bit wider so the extra bit catches the last bit shifted
  // out; with amount 0 that bit stays 0 by construction.
  assign amt     = s1_b[SHW-1:0];
  assign sll_ext = {1'b0, s1_a} << amt;
  assign srl_ext = {s1_a, 1'b0} >> amt;
  assign sra_ext = $signed({s1_a, 1'b0}) >>> amt;
  // Rotate by amt as two shifts; amount 0 makes the second shift WIDTH wide,
  // which yields zero and leaves the operand unchanged.
  assign rot_inv = (SHW+1)'(WIDTH) - {1'b0, amt};
  assign rol     = (s1_a << amt) | (s1_a >> rot_inv);
  assign ror     = (s1_a >> amt) | (s1_a << rot_inv);

  logic [WIDTH-1:0] res;
  logic             res_c;
  logic             res_v;
  logic             res_st;
  logic [WIDTH-1:0] res_wd;

  always_comb begin
    // NOTE: defaults first so every path assigns every output; a missed
    // branch would otherwise infer a latch.
    res    = '0;
    res_c  = 1'b0;
    res_v  = 1'b0;
    res_st = 1'b0;
    res_wd = '0;
    unique case (s1_cls)
      CLS_ARITH: begin
        case (s1_op)
          3'b000: begin {res_c, res} = add_sum; res_v = add_ovf; end
          3'b001: begin {res_c, res} = sub_sum; res_v = sub_ovf; end
          3'b010: res = {{(WIDTH-1){1'b0}}, slt};
          3'b011: res = {{(WIDTH-1){1'b0}}, sltu};
          default: ;
        endcase
      end
      CLS_LOGIC: begin
        case (s1_op)
          3'b000: res = s1_a & s1_b;
          3'b001: res = s1_a | s1_b;
          3'b010: res = s1_a ^ s1_b;
          3'b011: res = ~(s1_a | s1_b);
          3'b100: res = s1_b;
          default: ;
        endcase
      end
      CLS_SHIFT: begin
        case (s1_op)
          3'b000: {res_c, res} = sll_ext;
          3'b001: {res, res_c} = srl_ext;
          3'b010: {res, res_c} = sra_ext;
          3'b011: res = rol;
          3'b100: res = ror;
          default: ;
        endcase
      end
      CLS_MEM: begin
        res    = s1_a + s1_b;
        res_st = s1_op[0];
        if (s1_op[0]) res_wd = s1_d;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Stage 2 registers: hold while stalled or frozen
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid     <= 1'b0;
      aluout        <= '0;
      carry         <= 1'b0;
      overflow      <= 1'b0;
      mem_wr_en     <= 1'b0;
      mem_write_out <= '0;
    end else if (s2_adv) begin
      out_valid     <= s1_valid;
      aluout        <= res;
      carry         <= res_c;
      overflow      <= res_v;
      // A bubble must never raise a store request.
      mem_wr_en     <= s1_valid & res_st;
      mem_write_out <= res_wd;
    end
  end

endmodule

// File: tb/tb_dlx_exec_pipe.sv
// -----------------------------------------------------------------------------
// tb_dlx_exec_pipe
//   Scoreboard bench for dlx_exec_pipe. A 32-bit instance runs directed cases,
//   back-pressure, mid-flight reset and a random stream with random out_ready
//   and en_ex; a 16-bit instance runs a short directed + random stream.
//   Expected results come from an arithmetic reference model over 64-bit ints.
// -----------------------------------------------------------------------------
module tb_dlx_exec_pipe;

  typedef struct {
    string  tag;
    longint res;
    bit     c;
    bit     v;
    bit     we;
    longint wd;
    bit     chk_wd;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // ---------------- 32-bit instance ----------------
  logic        rst = 1'b1;
  logic        en_ex = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [5:0]  cntrl_in = '0;
  logic [31:0] src1 = '0, src2 = '0, imm = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] aluout, mem_write_out;
  logic        carry, overflow, mem_wr_en;

  dlx_exec_pipe #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .en_ex(en_ex),
    .in_valid(in_valid), .in_ready(in_ready), .cntrl_in(cntrl_in),
    .src1(src1), .src2(src2), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .aluout(aluout), .carry(carry), .overflow(overflow),
    .mem_wr_en(mem_wr_en), .mem_write_out(mem_write_out)
  );

  // ---------------- 16-bit instance ----------------
  logic        rst16 = 1'b1;
  logic        en16 = 1'b1;
  logic        in_valid16 = 1'b0;
  logic        in_ready16;
  logic [5:0]  cntrl16 = '0;
  logic [15:0] src1_16 = '0, src2_16 = '0, imm16 = '0;
  logic        out_valid16;
  logic        out_ready16 = 1'b1;
  logic [15:0] aluout16, wd16;
  logic        carry16, ovf16, we16;

  dlx_exec_pipe #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst16), .en_ex(en16),
    .in_valid(in_valid16), .in_ready(in_ready16), .cntrl_in(cntrl16),
    .src1(src1_16), .src2(src2_16), .imm(imm16),
    .out_valid(out_valid16), .out_ready(out_ready16),
    .aluout(aluout16), .carry(carry16), .overflow(ovf16),
    .mem_wr_en(we16), .mem_write_out(wd16)
  );

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic longint sx(int w, longint x);
    return (((x >> (w - 1)) & 1) != 0) ? x - (longint'(1) << w) : x;
  endfunction

  // Reference model: results derived from the instruction set rules using
  // plain integer arithmetic on w-bit values held in 64-bit integers.
  function automatic exp_t model(int w, bit [1:0] cls, bit [2:0] op, bit isel,
                                 longint a, longint s2, longint im, string tag);
    longint mask, lim, b, s, r;
    int     amt;
    exp_t   e;
    mask = (longint'(1) << w) - 1;
    lim  = longint'(1) << (w - 1);
    e.tag = tag; e.res = 0; e.c = 0; e.v = 0; e.we = 0; e.wd = 0; e.chk_wd = 0;
    b   = (isel || cls == 2'b11) ? im : s2;
    amt = int'(b % w);
    case (cls)
      2'b00: case (op)
        3'd0: begin
          s = a + b; e.res = s & mask; e.c = ((s >> w) & 1) != 0;
          s = sx(w, a) + sx(w, b); e.v = (s < -lim) || (s > lim - 1);
        end
        3'd1: begin
          s = a + ((~b) & mask) + 1; e.res = s & mask; e.c = ((s >> w) & 1) != 0;
          s = sx(w, a) - sx(w, b); e.v = (s < -lim) || (s > lim - 1);
        end
        3'd2: e.res = (sx(w, a) < sx(w, b)) ? 1 : 0;
        3'd3: e.res = (a < b) ? 1 : 0;
        default: e.res = 0;
      endcase
      2'b01: case (op)
        3'd0: e.res = a & b;
        3'd1: e.res = a | b;
        3'd2: e.res = a ^ b;
        3'd3: e.res = (~(a | b)) & mask;
        3'd4: e.res = b;
        default: e.res = 0;
      endcase
      2'b10: case (op)
        3'd0: begin e.res = (a << amt) & mask; e.c = (amt != 0) && (((a >> (w - amt)) & 1) != 0); end
        3'd1: begin e.res = a >> amt; e.c = (amt != 0) && (((a >> (amt - 1)) & 1) != 0); end
        3'd2: begin e.res = (sx(w, a) >>> amt) & mask; e.c = (amt != 0) && (((a >> (amt - 1)) & 1) != 0); end
        3'd3: begin r = a; repeat (amt) r = ((r << 1) | (r >> (w - 1))) & mask; e.res = r; end
        3'd4: begin r = a; repeat (amt) r = (r >> 1) | ((r & 1) << (w - 1)); e.res = r; end
        default: e.res = 0;
      endcase
      default: begin
        e.res = (a + im) & mask; e.we = op[0]; e.wd = op[0] ? s2 : 0; e.chk_wd = 1;
      end
    endcase
    return e;
  endfunction

  task automatic cmp(input exp_t e, input logic [63:0] r, input logic c, input logic v,
                     input logic we, input logic [63:0] wd);
    check({e.tag, "_aluout"}, r, e.res);
    check({e.tag, "_carry"}, c, e.c);
    check({e.tag, "_overflow"}, v, e.v);
    check({e.tag, "_mem_wr_en"}, we, e.we);
    if (e.chk_wd) check({e.tag, "_mem_write_out"}, wd, e.wd);
  endtask

  function automatic logic [31:0] rv();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // ---------------- 32-bit driver state ----------------
  exp_t q[$];
  bit   acc_now = 1'b0;   // current cycle's instruction will be taken at the next edge
  int   ready_mode = 0;   // 0: ready, 1: 1,0,0 pattern, 2: random, 3: never
  bit   en_rand = 1'b0;
  int   cyc = 0;

  task automatic drive_ctrl();
    case (ready_mode)
      0: out_ready = 1'b1;
      1: out_ready = (cyc % 3 == 0);
      2: out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
    en_ex = en_rand ? ($urandom_range(0, 4) != 0) : 1'b1;
    cyc++;
  endtask

  task automatic issue(input bit [1:0] cls, input bit [2:0] op, input bit isel,
                       input logic [31:0] a, input logic [31:0] b2, input logic [31:0] im,
                       input string tag);
    int waited;
    @(negedge clk);
    acc_now = 1'b0;
    drive_ctrl();
    in_valid = 1'b1; cntrl_in = {cls, isel, op}; src1 = a; src2 = b2; imm = im;
    #1;
    waited = 0;
    while (!in_ready && waited < 200) begin
      @(negedge clk);
      acc_now = 1'b0;
      drive_ctrl();
      #1;
      waited++;
    end
    if (!in_ready) check({tag, "_accept_timeout"}, in_ready, 1);
    else begin
      q.push_back(model(32, cls, op, isel, a, b2, im, tag));
      acc_now = 1'b1;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      acc_now = 1'b0;
      drive_ctrl();
      in_valid = 1'b0; cntrl_in = 6'($urandom); src1 = $urandom; src2 = $urandom; imm = $urandom;
      #1;
    end
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    acc_now = 1'b0; in_valid = 1'b0; en_ex = 1'b1; rst = 1'b1;
    q.delete();
    @(negedge clk);
    #1;
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_aluout"}, aluout, 0);
    check({tag, "_carry"}, carry, 0);
    check({tag, "_overflow"}, overflow, 0);
    check({tag, "_mem_wr_en"}, mem_wr_en, 0);
    check({tag, "_mem_write_out"}, mem_write_out, 0);
    check({tag, "_in_ready"}, in_ready, 1);
    rst = 1'b0;
  endtask

  // ---------------- 32-bit monitor ----------------
  task automatic monitor32_step();
    int   inflight;
    exp_t e;
    inflight = q.size() - (acc_now ? 1 : 0);
    if (!out_valid) check("idle_mem_wr_en", mem_wr_en, 0);
    if (inflight == 0) begin
      check("empty_out_valid", out_valid, 0);
      check("empty_in_ready", in_ready, en_ex);
    end
    if (inflight >= 2) begin
      check("full_out_valid", out_valid, 1);
      check("full_in_ready", in_ready, en_ex & out_ready);
    end
    if (out_valid && out_ready && en_ex && inflight > 0) begin
      e = q.pop_front();
      cmp(e, aluout, carry, overflow, mem_wr_en, mem_write_out);
    end
  endtask

  initial begin : mon32
    forever begin
      @(negedge clk);
      #2;
      if (!rst) monitor32_step();
    end
  end

  // ---------------- 16-bit driver and monitor ----------------
  exp_t q16[$];
  bit   done16 = 1'b0;

  task automatic issue16(input bit [1:0] cls, input bit [2:0] op, input bit isel,
                         input logic [15:0] a, input logic [15:0] b2, input logic [15:0] im,
                         input string tag);
    @(negedge clk);
    in_valid16 = 1'b1; cntrl16 = {cls, isel, op}; src1_16 = a; src2_16 = b2; imm16 = im;
    #1;
    check({tag, "_in_ready"}, in_ready16, 1);
    q16.push_back(model(16, cls, op, isel, a, b2, im, tag));
  endtask

  initial begin : drv16
    repeat (3) @(negedge clk);
    rst16 = 1'b0;
    issue16(2'b10, 3'd0, 1'b0, 16'h1234, 16'h0013, 16'h0000, "w16_sll_b13");
    issue16(2'b00, 3'd0, 1'b0, 16'hFFFF, 16'h0001, 16'h0000, "w16_add_carry");
    issue16(2'b00, 3'd1, 1'b1, 16'h8000, 16'h0000, 16'h0001, "w16_sub_ovf");
    issue16(2'b10, 3'd2, 1'b1, 16'h8001, 16'h0000, 16'h0011, "w16_sra_b11");
    issue16(2'b10, 3'd3, 1'b0, 16'h8001, 16'h00F4, 16'h0000, "w16_rol");
    issue16(2'b11, 3'd1, 1'b0, 16'h0010, 16'hBEEF, 16'hFFFE, "w16_store");
    repeat (60) begin
      logic [31:0] a, b, m;
      a = rv(); b = rv(); m = rv();
      issue16(2'($urandom), 3'($urandom), 1'($urandom), a[15:0], b[15:0], m[15:0], "w16_rnd");
    end
    @(negedge clk);
    in_valid16 = 1'b0;
    done16 = 1'b1;
  end

  initial begin : mon16
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst16) begin
        if (!out_valid16) check("w16_idle_mem_wr_en", we16, 0);
        if (out_valid16) begin
          if (q16.size() == 0) check("w16_spurious_out_valid", out_valid16, 0);
          else begin
            e = q16.pop_front();
            cmp(e, aluout16, carry16, ovf16, we16, wd16);
          end
        end
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: time limit reached, checks=%0d", checks);
    $fatal(1, "simulation time limit");
  end

  // ---------------- main sequence ----------------
  initial begin : main
    int n;
    do_reset("reset");

    // First result two cycles after it is presented.
    issue(2'b00, 3'd0, 1'b0, 32'hFFFF_FFFF, 32'h1, 32'h0, "add_carry");
    idle(1);
    check("lat_early_out_valid", out_valid, 0);
    idle(1);
    check("lat_due_out_valid", out_valid, 1);

    issue(2'b00, 3'd0, 1'b0, 32'h7FFF_FFFF, 32'h1, 32'h0, "add_ovf");
    issue(2'b00, 3'd1, 1'b0, 32'd5, 32'd7, 32'h0, "sub_borrow");
    issue(2'b00, 3'd2, 1'b0, 32'hFFFF_FFFF, 32'h1, 32'h0, "slt");
    issue(2'b00, 3'd3, 1'b0, 32'hFFFF_FFFF, 32'h1, 32'h0, "sltu");
    issue(2'b00, 3'd5, 1'b0, 32'h1234_5678, 32'h1, 32'h0, "arith_rsvd");
    issue(2'b10, 3'd2, 1'b0, 32'h8000_0000, 32'd4, 32'h0, "sra");
    issue(2'b10, 3'd0, 1'b0, 32'h8000_0001, 32'd1, 32'h0, "sll");
    issue(2'b10, 3'd4, 1'b0, 32'h0000_0001, 32'd1, 32'h0, "ror");
    issue(2'b10, 3'd3, 1'b1, 32'h8000_0001, 32'h0, 32'h24, "rol_imm");
    issue(2'b10, 3'd1, 1'b0, 32'hF000_000F, 32'd0, 32'h0, "srl_zero");
    issue(2'b01, 3'd3, 1'b1, 32'h0F0F_0000, 32'h0, 32'h00FF_00F0, "nor_imm");
    issue(2'b01, 3'd4, 1'b1, 32'h1111_1111, 32'h2, 32'hCAFE_F00D, "passb_imm");
    issue(2'b01, 3'd6, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, "logic_rsvd");
    issue(2'b11, 3'd1, 1'b0, 32'h100, 32'hDEAD, 32'hFFFF_FFFC, "store");
    issue(2'b11, 3'd0, 1'b0, 32'h100, 32'hDEAD, 32'h8, "load");
    idle(3);

    // Back-to-back ADD stream under a 1,0,0 out_ready pattern.
    cyc = 0;
    ready_mode = 1;
    for (int i = 0; i < 8; i++) issue(2'b00, 3'd0, 1'b0, rv(), rv(), 32'h0, "stream_add");
    idle(12);
    ready_mode = 0;
    idle(2);

    // Two in flight, then reset: both must vanish.
    ready_mode = 3;
    issue(2'b00, 3'd0, 1'b0, 32'h1, 32'h2, 32'h0, "flush_a");
    issue(2'b01, 3'd1, 1'b0, 32'h4, 32'h8, 32'h0, "flush_b");
    idle(1);
    do_reset("mid_reset");
    ready_mode = 0;
    idle(5);

    // Random stream with random back-pressure and enable.
    ready_mode = 2;
    en_rand = 1'b1;
    repeat (300) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      issue(2'($urandom), 3'($urandom), 1'($urandom), rv(), rv(), rv(), "rnd");
    end

    ready_mode = 0;
    en_rand = 1'b0;
    n = 0;
    while (q.size() > 0 && n < 50) begin idle(1); n++; end
    idle(2);
    check("drain32_queue", q.size(), 0);

    n = 0;
    while (!(done16 && q16.size() == 0) && n < 300) begin idle(1); n++; end
    check("drain16_done", done16, 1);
    check("drain16_queue", q16.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
